// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encodings, default watchdog length
// and the index-width helper used by the interface, the top and the round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

    // A single requester still needs a 1-bit index so grant_id never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundles the requester handshake, the uart_tx load/done pair and the arbiter status lines.
// The arbiter uses the master view; the requesters plus transmitter side uses the slave view.
interface uart_tx_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4
);
    localparam int IDX_W = uart_arb_pkg::idx_width(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic                        tx_wr_en;
    logic [DATA_WIDTH-1:0]       tx_din;
    logic                        tx_done;
    logic [IDX_W-1:0]            grant_id;
    logic                        busy;
    logic                        timeout_err;

    modport master (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_wr_en, tx_din, grant_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_wr_en, tx_din, grant_id, busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = uart_arb_pkg::idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    int               j;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        found     = 1'b0;
        j         = 0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            idx = IDX_W'(j);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between N_REQ byte-stream requesters with round-robin, message-granular
// grants, one load strobe per byte and a watchdog on the transmitter's done pulse.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic           clk,
    input logic           rst,
    uart_tx_arb_if.master bus
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [DATA_WIDTH-1:0] txDin_q, txDin_d;
    logic                  last_q, last_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  wrEn_q, wrEn_d;
    logic [N_REQ-1:0]      ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  timeoutErr_q, timeoutErr_d;

    logic [N_REQ-1:0]      rrGnt;
    logic [IDX_W-1:0]      rrIdx;
    logic                  rrAny;
    logic [TMR_W-1:0]      timerInc;
    logic                  timerExpired;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (rrGnt),
        .gnt_idx_o (rrIdx),
        .any_o     (rrAny)
    );

    assign timerInc     = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    assign timerExpired = (timer_q >= TMR_LAST);

    // Every output is computed from the next state so the registered copy lines up with the state.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        txDin_d      = txDin_q;
        last_d       = last_q;
        timer_d      = timer_q;
        wrEn_d       = 1'b0;
        ready_d      = '0;
        timeoutErr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rrAny) begin
                    grant_d = rrIdx;
                    txDin_d = bus.req_data[int'(rrIdx)*DATA_WIDTH +: DATA_WIDTH];
                    last_d  = bus.req_last[rrIdx];
                    ptr_d   = (rrIdx == IDX_LAST) ? '0 : rrIdx + 1'b1;
                    wrEn_d  = 1'b1;
                    ready_d = rrGnt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timerInc;
                if (bus.tx_done) begin
                    timer_d = '0;
                    state_d = last_q ? IDLE : HOLD;
                end else if (timerExpired) begin
                    timeoutErr_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            HOLD: begin
                timer_d = timerInc;
                // Only the current owner may continue; everyone else waits for IDLE.
                if (bus.req_valid[grant_q]) begin
                    txDin_d = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                    last_d  = bus.req_last[grant_q];
                    wrEn_d  = 1'b1;
                    ready_d = N_REQ'(1) << grant_q;
                    state_d = LOAD;
                end else if (timerExpired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            txDin_q      <= '0;
            last_q       <= 1'b0;
            timer_q      <= '0;
            wrEn_q       <= 1'b0;
            ready_q      <= '0;
            busy_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            txDin_q      <= txDin_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            wrEn_q       <= wrEn_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.tx_wr_en    = wrEn_q;
    assign bus.tx_din      = txDin_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: requester queues feed bytes, a uart_tx stand-in returns
// tx_done after a per-byte delay, and each load strobe is matched against the expected queue.
module tb_uart_tx_arb;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int TMO = 16;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic       last;
        int         doneDelay;
        bit         chkLat;
        bit         chkGap;
    } expT;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic       last;
    } byteT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    expT  expQ[$];
    byteT pendQ[$];

    int checkCount    = 0;
    int passCount     = 0;
    int doneAt        = -1;
    int lastDoneCyc   = 0;
    int withheldWrCyc = 0;
    int terrCount     = 0;
    int terrCyc       = 0;
    int validRise[NR];
    logic [NR-1:0] prevValid = '0;

    uart_tx_arb_if #(.DATA_WIDTH(DW), .N_REQ(NR)) bus ();

    uart_tx_arb #(.DATA_WIDTH(DW), .N_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last,
                                 input int doneDelay, input bit chkLat, input bit chkGap);
        byteT b;
        expT  e;
        b.req  = req;
        b.data = data;
        b.last = last;
        pendQ.push_back(b);
        e.req       = req;
        e.data      = data;
        e.last      = last;
        e.doneDelay = doneDelay;
        e.chkLat    = chkLat;
        e.chkGap    = chkGap;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget, output int fallCyc);
        bit ok;
        ok      = 1'b0;
        fallCyc = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (expQ.size() == 0 && pendQ.size() == 0 && bus.busy == 1'b0) begin
                ok      = 1'b1;
                fallCyc = cyc;
            end
        end
        checkOutput("drain_done", {31'd0, ok}, 32'd1);
    endtask

    task automatic waitExpSize(input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (expQ.size() == n) ok = 1'b1;
        end
        checkOutput("sb_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic resetDut();
        rst = 1'b0;
        pendQ.delete();
        expQ.delete();
        doneAt = -1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({pfx, "_wr_en"}, {31'd0, bus.tx_wr_en}, 32'd0);
        checkOutput({pfx, "_ready"}, {28'd0, bus.req_ready}, 32'd0);
        checkOutput({pfx, "_grant"}, {30'd0, bus.grant_id}, 32'd0);
        checkOutput({pfx, "_din"}, {24'd0, bus.tx_din}, 32'd0);
        checkOutput({pfx, "_terr"}, {31'd0, bus.timeout_err}, 32'd0);
    endtask

    // Requesters, transmitter stand-in and output monitor all act on the falling edge.
    initial begin
        expT           e;
        logic [NR-1:0] nv;
        logic [NR*DW-1:0] nd;
        logic [NR-1:0] nl;
        bit            seen;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_wr_en) begin
                checkOutput("sb_nonempty", {31'd0, expQ.size() > 0}, 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("grant_id", {30'd0, bus.grant_id}, e.req);
                    checkOutput("tx_din", {24'd0, bus.tx_din}, {24'd0, e.data});
                    checkOutput("req_ready", {28'd0, bus.req_ready}, 32'd1 << e.req);
                    if (e.chkLat) checkOutput("latency", cyc - validRise[e.req], 32'd1);
                    if (e.chkGap) checkOutput("done_to_wr", cyc - lastDoneCyc, 32'd2);
                    if (e.doneDelay >= 0) begin
                        doneAt = cyc + e.doneDelay;
                    end else begin
                        doneAt        = -1;
                        withheldWrCyc = cyc;
                    end
                end
            end else if (bus.req_ready != '0) begin
                checkOutput("stray_ready", {28'd0, bus.req_ready}, 32'd0);
            end
            if (bus.timeout_err) begin
                terrCount++;
                terrCyc = cyc;
            end
            bus.tx_done = (doneAt >= 0 && cyc == doneAt);
            if (bus.tx_done) begin
                lastDoneCyc = cyc;
                doneAt      = -1;
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) begin
                    seen = 1'b0;
                    for (int k = 0; k < pendQ.size(); k++) begin
                        if (!seen && pendQ[k].req == i) begin
                            pendQ.delete(k);
                            seen = 1'b1;
                        end
                    end
                end
            end
            nv = '0;
            nd = '0;
            nl = '0;
            for (int k = 0; k < pendQ.size(); k++) begin
                if (!nv[pendQ[k].req]) begin
                    nv[pendQ[k].req]          = 1'b1;
                    nd[pendQ[k].req*DW +: DW] = pendQ[k].data;
                    nl[pendQ[k].req]          = pendQ[k].last;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (nv[i] && !prevValid[i]) validRise[i] = cyc;
            end
            prevValid     = nv;
            bus.req_valid = nv;
            bus.req_data  = nd;
            bus.req_last  = nl;
        end
    end

    initial begin
        int fall;
        int t0;

        repeat (2) tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        $display("[TB] single byte from requester 0");
        applyStimulus(0, 8'hA5, 1'b1, 5, 1'b1, 1'b0);
        waitDrain(100, fall);
        checkOutput("t1_busy_drop", fall - lastDoneCyc, 32'd1);

        $display("[TB] round robin over requesters 0..2");
        resetDut();
        applyStimulus(0, 8'h10, 1'b1, 10, 1'b0, 1'b0);
        applyStimulus(1, 8'h21, 1'b1, 10, 1'b0, 1'b0);
        applyStimulus(2, 8'h32, 1'b1, 10, 1'b0, 1'b0);
        applyStimulus(0, 8'h13, 1'b1, 10, 1'b0, 1'b0);
        applyStimulus(1, 8'h24, 1'b1, 10, 1'b0, 1'b0);
        waitDrain(300, fall);

        $display("[TB] three-byte message holds the grant");
        resetDut();
        applyStimulus(1, 8'h11, 1'b0, 6, 1'b0, 1'b0);
        applyStimulus(1, 8'h22, 1'b0, 6, 1'b0, 1'b1);
        applyStimulus(1, 8'h33, 1'b1, 6, 1'b0, 1'b1);
        waitExpSize(2, 50);
        applyStimulus(0, 8'h44, 1'b1, 6, 1'b0, 1'b0);
        waitDrain(200, fall);

        $display("[TB] watchdog in WAIT");
        resetDut();
        t0 = terrCount;
        applyStimulus(0, 8'hB0, 1'b1, -1, 1'b0, 1'b0);
        applyStimulus(1, 8'hC0, 1'b1, 4, 1'b0, 1'b0);
        applyStimulus(0, 8'hB1, 1'b1, 4, 1'b0, 1'b0);
        waitDrain(200, fall);
        checkOutput("t4_terr_count", terrCount - t0, 32'd1);
        checkOutput("t4_terr_cycle", terrCyc - withheldWrCyc, 32'd17);

        $display("[TB] watchdog in HOLD");
        resetDut();
        t0 = terrCount;
        applyStimulus(0, 8'h5E, 1'b0, 3, 1'b0, 1'b0);
        waitDrain(100, fall);
        checkOutput("t5_hold_exit", fall - lastDoneCyc, 32'd17);
        checkOutput("t5_no_terr", terrCount - t0, 32'd0);

        $display("[TB] reset during WAIT");
        resetDut();
        applyStimulus(0, 8'h5A, 1'b1, -1, 1'b0, 1'b0);
        waitExpSize(0, 20);
        repeat (3) tick();
        checkOutput("t6_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        checkAllZero("t6");
        pendQ.delete();
        expQ.delete();
        doneAt = -1;
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(1, 8'h61, 1'b1, 3, 1'b1, 1'b0);
        applyStimulus(3, 8'h63, 1'b1, 3, 1'b0, 1'b0);
        waitDrain(100, fall);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
